// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers: 32-cycle shift-add multiply
// and restoring divide. The divider datapath is compiled in only when MDU_DIV_EN is defined.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state_o
);

  // Debug encoding on dbg_state_o: 0 IDLE, 1 MUL, 2 DIV, 3 DONE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        signed_op;
  logic        last_iter;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_res;

  // Handshake: start is a request sampled at posedge; it is taken only in IDLE or DONE, and a
  // start seen while busy is dropped without touching the latched operands.
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_mag    = (signed_op && rs[31]) ? (~rs + 32'd1) : rs;
  assign rt_mag    = (signed_op && rt[31]) ? (~rt + 32'd1) : rt;
  assign last_iter = (cnt_q == 6'd31);

  // acc holds {partial product, remaining multiplier bits}; one multiplier bit retires per cycle
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign mul_res  = neg_q ? (~mul_next + 64'd1) : mul_next;

`ifdef MDU_DIV_EN
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [31:0] quo_res, rem_res;

  // acc holds {partial remainder, dividend bits shifting into quotient bits}
  assign div_ge   = acc_q[63:31] >= {1'b0, opb_q};
  assign div_rem  = div_ge ? (acc_q[62:31] - opb_q) : acc_q[62:31];
  assign div_next = {div_rem, acc_q[30:0], div_ge};
  assign quo_res  = dz_q ? 32'hFFFF_FFFF
                         : (neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0]);
  assign rem_res  = rneg_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: state_d = S_MUL;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU:   state_d = S_DIV;
`else
            OP_DIV, OP_DIVU:   state_d = S_DONE;
`endif
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_MUL:   if (last_iter) state_d = S_DONE;
      S_DIV:   if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state_q == S_MUL) || (state_q == S_DIV);
    done        = (state_q == S_DONE);
    dbg_state_o = state_q;
  end

  // Datapath next state; hi/lo change only on MTHI/MTLO or at the final iteration
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    neg_d = neg_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
`ifdef MDU_DIV_EN
    rneg_d = rneg_q;
    dz_d   = dz_q;
`endif
    if (accept) begin
      cnt_d = 6'd0;
      case (op)
        OP_MULT, OP_MULTU: begin
          acc_d = {32'd0, rt_mag};
          opb_d = rs_mag;
          neg_d = signed_op && (rs[31] ^ rt[31]);
        end
`ifdef MDU_DIV_EN
        OP_DIV, OP_DIVU: begin
          acc_d  = {32'd0, rs_mag};
          opb_d  = rt_mag;
          neg_d  = signed_op && (rs[31] ^ rt[31]);
          rneg_d = signed_op && rs[31];
          dz_d   = (rt == 32'd0);
        end
`endif
        OP_MTHI: hi_d = rs;
        OP_MTLO: lo_d = rs;
        default: ;
      endcase
    end else if (state_q == S_MUL) begin
      acc_d = mul_next;
      cnt_d = last_iter ? 6'd0 : cnt_q + 6'd1;
      if (last_iter) begin
        hi_d = mul_res[63:32];
        lo_d = mul_res[31:0];
      end
    end
`ifdef MDU_DIV_EN
    else if (state_q == S_DIV) begin
      acc_d = div_next;
      cnt_d = last_iter ? 6'd0 : cnt_q + 6'd1;
      if (last_iter) begin
        hi_d = rem_res;
        lo_d = quo_res;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 6'd0;
      acc_q <= 64'd0;
      opb_q <= 32'd0;
      neg_q <= 1'b0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      neg_q <= neg_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end
`endif

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL: reset rst, asynchronous, active-high; clock clk.
REQ-002 SHALL provide ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  operation request, sampled at posedge clk
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- rs  in  32  operand A / dividend / MTHI-MTLO source
- rt  in  32  operand B / divisor
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse, HI/LO result valid
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-004 SHALL accept start only in IDLE or DONE; start in MUL or DIV is ignored, and operands are not re-sampled.
REQ-005 SHALL, on accepted MULT/MULTU/DIV/DIVU, latch rs/rt at that edge, enter MUL or DIV, and assert busy for exactly 32 cycles, starting the cycle after acceptance.
REQ-006 SHALL perform one iteration per cycle: shift-add multiply or restoring divide, using a 6-bit iteration counter 0..31.
REQ-007 SHALL, at the edge ending the 32nd busy cycle, update hi/lo, deassert busy and enter DONE; done is high for exactly that one cycle (cycle 33 after acceptance).
REQ-008 SHALL leave DONE after one cycle: to IDLE, or directly into a new operation if start is accepted in DONE.
REQ-009 MULTU: {hi,lo} = rs*rt unsigned, 64-bit.
REQ-010 MULT: {hi,lo} = rs*rt two's-complement, 64-bit; implemented on magnitudes, product negated when sign(rs)^sign(rt).
REQ-011 DIVU: lo = rs/rt, hi = rs%rt, unsigned.
REQ-012 DIV: quotient truncated toward zero; remainder sign = sign(rs); quotient negated when sign(rs)^sign(rt).
REQ-013 SHALL give DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-014 SHALL give divide by zero (DIV or DIVU, rt=0): lo=0xFFFFFFFF, hi=rs, with the normal 32-cycle latency and done pulse.
REQ-015 MTHI/MTLO SHALL write hi/lo from rs at the accepting edge: no busy, no done, FSM stays/returns IDLE; ignored while busy.
REQ-016 hi/lo SHALL hold their values during MUL/DIV; intermediate state lives in internal registers only.
REQ-017 No-op codes SHALL have no effect.

Reset
REQ-018 SHALL on rst (any cycle, including mid-operation) immediately enter IDLE: busy=0, done=0, hi=0, lo=0, counter=0; an in-flight operation is discarded.
REQ-019 SHALL, on the first posedge after rst deasserts, accept start normally.

Configuration
REQ-020 Macro MDU_DIV_EN:
- defined: divider datapath compiled in; DIV/DIVU per REQ-011..014.
- undefined: no divider logic. DIV/DIVU are accepted, busy is not asserted, done pulses the cycle after acceptance, and hi/lo are unchanged.
- MULT/MULTU/MTHI/MTLO are identical in both builds.

Verification
REQ-021 Bench SHALL cover:
- MULTU rs=0xFFFFFFFF rt=0x00000002 -> busy 32 cycles, done in cycle 33: hi=0x00000001, lo=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD(-3) rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9(-7) rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=100 rt=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- Second start (MULTU 5*5) at busy cycle 10 of a MULTU 3*4 -> ignored; hi=0, lo=0x0000000C.
- start in the done cycle -> back-to-back operation, busy next cycle.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 -> hi/lo updated one edge each; busy and done stay low.
- rst asserted at busy cycle 15 of a DIV -> busy=0, done=0, hi=lo=0 immediately; no done pulse afterwards.
- Build without MDU_DIV_EN: DIVU 10/3 -> done next cycle, hi/lo unchanged.
